hazard_monitor: RTL and testbench
=================================

HAZARD_MONITOR -- requirements
Module: hazard_monitor

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-high.
REQ-002 Parameter N_ZONES SHALL default to 4 and set the number of monitored zones (1..16).
REQ-003 Parameter DEBOUNCE SHALL default to 8 and set the consecutive-sample count needed to accept a sensor change (2..255).
REQ-004 Parameter SYNC_STAGES SHALL default to 2 and set the input synchroniser depth (>=2).
REQ-005 Port clk  input  1  system clock, all logic on rising edge.
REQ-006 Port rst  input  1  synchronous active-high reset.
REQ-007 Port IG  input  N_ZONES  gas sensor, bit z = zone z, asynchronous.
REQ-008 Port IS  input  N_ZONES  smoke sensor per zone, asynchronous.
REQ-009 Port IH  input  N_ZONES  humidity sensor per zone, asynchronous.
REQ-010 Port IT  input  N_ZONES  temperature sensor per zone, asynchronous.
REQ-011 Port Iack  input  N_ZONES  operator acknowledge per zone, synchronous to clk, level-sampled.
REQ-012 Port Ored  output  1  any zone in ALARM or HELD.
REQ-013 Port Oyellow  output  1  no red zone and at least one zone in WARN.
REQ-014 Port Ogreen  output  1  every zone in SAFE.
REQ-015 Port Ored_zones  output  N_ZONES  per-zone red status (ALARM or HELD).

Function
REQ-016 Each sensor bit SHALL pass through a SYNC_STAGES flop synchroniser before any other use.
REQ-017 Each synchronised bit SHALL have a debounced copy that changes only after the synchronised value differs from it for DEBOUNCE consecutive cycles; any matching sample clears the counter.
REQ-018 Per zone, classification from debounced G,S,H,T: RED = T&(S|G); WARN = ~RED & ((T&~S&~G) | (~T&S&H) | (~T&G)); SAFE otherwise.
REQ-019 Per-zone FSM states SHALL be SAFE, WARN, ALARM, HELD.
REQ-020 From SAFE or WARN: RED -> ALARM; WARN -> WARN; SAFE -> SAFE.
REQ-021 ALARM -> HELD when RED drops; Iack asserted while in ALARM SHALL be ignored.
REQ-022 HELD remains latched until Iack[z]=1, then goes to the current classification (SAFE or WARN); if RED reasserts while in HELD, go to ALARM regardless of Iack (RED has priority).
REQ-023 Aggregate outputs SHALL be registered and one-hot across Ored/Oyellow/Ogreen every cycle after reset.
REQ-024 Latency from a stable sensor edge to aggregate output SHALL be exactly SYNC_STAGES+DEBOUNCE+2 clock edges (sync, debounce, FSM, output register).
REQ-025 Input glitches shorter than DEBOUNCE cycles after synchronisation SHALL produce no state change.
REQ-026 Zones SHALL be fully independent; Iack[z] affects only zone z.

Reset
REQ-027 While rst=1: all FSMs SAFE, debounced values 0, counters 0, synchroniser flops 0, Ogreen=1, Ored=0, Oyellow=0, Ored_zones=0.
REQ-028 Reset asserted mid-debounce or in HELD SHALL discard all latched alarms; the first output update after release follows REQ-024 timing.

Structure
REQ-029 Package hazard_pkg SHALL hold the zone state enum (SAFE, WARN, ALARM, HELD) and default constants for N_ZONES, DEBOUNCE, SYNC_STAGES.
REQ-030 Sub-module hazard_zone SHALL implement one zone (4 synchronisers, 4 debouncers, classifier, FSM) and be instantiated N_ZONES times by generate; aggregation stays in the top.

Verification (N_ZONES=2, DEBOUNCE=4, SYNC_STAGES=2)
REQ-031 Reset release, all sensors 0 -> Ogreen=1, Ored=Oyellow=0, Ored_zones=2'b00.
REQ-032 IT[0]=1, IS[0]=1 stable from edge k -> Ored=1, Ored_zones=2'b01 at edge k+8, not at k+7.
REQ-033 IG[1] pulse of 3 cycles -> outputs unchanged (Ogreen stays 1).
REQ-034 Zone 0 in ALARM, sensors cleared -> Ored stays 1 (HELD); Iack[0]=1 one cycle -> Ogreen=1 next edge+1; Iack[0] during ALARM -> no change.
REQ-035 Zone 0 HELD, zone 1 WARN (IT[1] only), Iack[0] -> Oyellow=1; then rst mid-HELD -> Ogreen=1 next cycle.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and default constants for the hazard monitor.
package hazard_pkg;

  localparam int unsigned DEF_N_ZONES     = 4;
  localparam int unsigned DEF_DEBOUNCE    = 8;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned NUM_SENSORS     = 4;

  // Per-zone supervisory state.
  typedef enum logic [1:0] {
    SAFE  = 2'd0,
    WARN  = 2'd1,
    ALARM = 2'd2,
    HELD  = 2'd3
  } zone_state_t;

  // Instantaneous classification of one zone's debounced sensors.
  typedef enum logic [1:0] {
    CLS_SAFE = 2'd0,
    CLS_WARN = 2'd1,
    CLS_RED  = 2'd2
  } zone_class_t;

  // Red dominates; warn covers heat alone, smoke with humidity, or gas without heat.
  function automatic zone_class_t classify(input logic g, input logic s,
                                           input logic h, input logic t);
    logic red;
    logic warn;
    red  = t & (s | g);
    warn = ~red & ((t & ~s & ~g) | (~t & s & h) | (~t & g));
    if (red)       return CLS_RED;
    else if (warn) return CLS_WARN;
    else           return CLS_SAFE;
  endfunction

endpackage

// File: rtl/hazard_zone.sv
// One monitored zone: synchronisers, debouncers, classifier and latching FSM.
module hazard_zone
  import hazard_pkg::*;
#(
  parameter int unsigned DEBOUNCE    = DEF_DEBOUNCE,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        g,
  input  logic        s,
  input  logic        h,
  input  logic        t,
  input  logic        ack,
  output zone_state_t state
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE);

  logic [NUM_SENSORS-1:0] sens_c;
  logic [NUM_SENSORS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SENSORS-1:0] deb_q;
  logic [CNT_W-1:0]       cnt_q  [NUM_SENSORS];
  zone_state_t            state_q;
  zone_state_t            state_d;
  zone_class_t            cls_c;

  // Bit order inside the zone: {t, h, s, g}.
  assign sens_c = {t, h, s, g};

  // Multi-flop synchroniser for the asynchronous sensor inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= sens_c;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Accept a new sensor level only after DEBOUNCE consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q <= '0;
      for (int b = 0; b < int'(NUM_SENSORS); b++) cnt_q[b] <= '0;
    end else begin
      for (int b = 0; b < int'(NUM_SENSORS); b++) begin
        if (sync_q[SYNC_STAGES-1][b] == deb_q[b]) begin
          cnt_q[b] <= '0;
        end else if (cnt_q[b] == CNT_W'(DEBOUNCE - 1)) begin
          deb_q[b] <= sync_q[SYNC_STAGES-1][b];
          cnt_q[b] <= '0;
        end else begin
          cnt_q[b] <= cnt_q[b] + CNT_W'(1);
        end
      end
    end
  end

  assign cls_c = classify(deb_q[0], deb_q[1], deb_q[2], deb_q[3]);

  // Zone state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= SAFE;
    else     state_q <= state_d;
  end

  // Next-state: red always wins; HELD waits for an acknowledge before following the classifier.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SAFE, WARN: begin
        if (cls_c == CLS_RED)       state_d = ALARM;
        else if (cls_c == CLS_WARN) state_d = WARN;
        else                        state_d = SAFE;
      end
      ALARM: begin
        if (cls_c != CLS_RED) state_d = HELD;
      end
      HELD: begin
        if (cls_c == CLS_RED)       state_d = ALARM;
        else if (ack)               state_d = (cls_c == CLS_WARN) ? WARN : SAFE;
      end
      default: state_d = SAFE;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/hazard_monitor.sv
// Multi-zone hazard monitor with registered traffic-light aggregation.
module hazard_monitor
  import hazard_pkg::*;
#(
  parameter int unsigned N_ZONES     = DEF_N_ZONES,
  parameter int unsigned DEBOUNCE    = DEF_DEBOUNCE,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_ZONES-1:0] IG,
  input  logic [N_ZONES-1:0] IS,
  input  logic [N_ZONES-1:0] IH,
  input  logic [N_ZONES-1:0] IT,
  input  logic [N_ZONES-1:0] Iack,
  output logic               Ored,
  output logic               Oyellow,
  output logic               Ogreen,
  output logic [N_ZONES-1:0] Ored_zones
);

  zone_state_t        zstate [N_ZONES];
  logic [N_ZONES-1:0] red_c;
  logic               warn_c;
  logic               safe_c;

  for (genvar z = 0; z < int'(N_ZONES); z++) begin : g_zone
    hazard_zone #(
      .DEBOUNCE    (DEBOUNCE),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_zone (
      .clk   (clk),
      .rst   (rst),
      .g     (IG[z]),
      .s     (IS[z]),
      .h     (IH[z]),
      .t     (IT[z]),
      .ack   (Iack[z]),
      .state (zstate[z])
    );
  end

  // Decode zone states into red / warn / all-safe summaries.
  always_comb begin
    red_c  = '0;
    warn_c = 1'b0;
    safe_c = 1'b1;
    for (int z = 0; z < int'(N_ZONES); z++) begin
      red_c[z] = (zstate[z] == ALARM) || (zstate[z] == HELD);
      if (zstate[z] == WARN) warn_c = 1'b1;
      if (zstate[z] != SAFE) safe_c = 1'b0;
    end
  end

  // Output register; red beats yellow, green only when everything is safe.
  always_ff @(posedge clk) begin
    if (rst) begin
      Ored       <= 1'b0;
      Oyellow    <= 1'b0;
      Ogreen     <= 1'b1;
      Ored_zones <= '0;
    end else begin
      Ored       <= |red_c;
      Oyellow    <= ~(|red_c) & warn_c;
      Ogreen     <= safe_c;
      Ored_zones <= red_c;
    end
  end

endmodule

// File: tb/tb_hazard_monitor.sv
// Directed self-checking bench for hazard_monitor (2 zones, debounce 4, 2 sync stages).
module tb_hazard_monitor;

  localparam int unsigned NZ = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NZ-1:0] IG, IS, IH, IT, Iack;
  logic          Ored, Oyellow, Ogreen;
  logic [NZ-1:0] Ored_zones;

  int n_checks = 0;
  int n_errors = 0;

  hazard_monitor #(
    .N_ZONES     (NZ),
    .DEBOUNCE    (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .IG         (IG),
    .IS         (IS),
    .IH         (IH),
    .IT         (IT),
    .Iack       (Iack),
    .Ored       (Ored),
    .Oyellow    (Oyellow),
    .Ogreen     (Ogreen),
    .Ored_zones (Ored_zones)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge, settle, and confirm the light outputs stay one-hot.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("onehot", 32'($countones({Ored, Oyellow, Ogreen})), 32'd1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic lights(input string tag, input logic r, input logic y, input logic g,
                        input logic [NZ-1:0] rz);
    chk({tag, ".red"},    32'(Ored),       32'(r));
    chk({tag, ".yellow"}, 32'(Oyellow),    32'(y));
    chk({tag, ".green"},  32'(Ogreen),     32'(g));
    chk({tag, ".zones"},  32'(Ored_zones), 32'(rz));
  endtask

  initial begin
    rst = 1'b1; IG = '0; IS = '0; IH = '0; IT = '0; Iack = '0;
    ticks(3);
    lights("in_reset", 1'b0, 1'b0, 1'b1, 2'b00);
    rst = 1'b0;
    ticks(10);
    lights("post_reset", 1'b0, 1'b0, 1'b1, 2'b00);

    // Zone 0 red: exact pipeline latency of 8 edges.
    IT[0] = 1'b1; IS[0] = 1'b1;
    ticks(7);
    lights("red_edge7", 1'b0, 1'b0, 1'b1, 2'b00);
    tick();
    lights("red_edge8", 1'b1, 1'b0, 1'b0, 2'b01);

    // Acknowledge while in ALARM is ignored.
    Iack = 2'b01;
    tick();
    Iack = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ack_in_alarm", 32'(Ored_zones), 32'h1);
    end

    // Clear sensors: zone 0 latches in HELD.
    IT[0] = 1'b0; IS[0] = 1'b0;
    ticks(12);
    lights("held", 1'b1, 1'b0, 1'b0, 2'b01);

    // Acknowledge of the other zone has no effect on zone 0.
    Iack = 2'b10;
    tick();
    Iack = 2'b00;
    ticks(2);
    lights("ack_other_zone", 1'b1, 1'b0, 1'b0, 2'b01);

    // Acknowledge zone 0: safe visible two edges later.
    Iack = 2'b01;
    tick();
    Iack = 2'b00;
    chk("ack_edge1.red", 32'(Ored), 32'd1);
    tick();
    lights("ack_edge2", 1'b0, 1'b0, 1'b1, 2'b00);

    // Three-cycle gas glitch on zone 1 must be filtered.
    IG[1] = 1'b1;
    ticks(3);
    IG[1] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("glitch.green", 32'(Ogreen), 32'd1);
    end

    // Zone 0 HELD, zone 1 WARN, then acknowledge zone 0 -> yellow.
    IT[0] = 1'b1; IS[0] = 1'b1;
    ticks(8);
    IT[0] = 1'b0; IS[0] = 1'b0;
    ticks(10);
    IT[1] = 1'b1;
    ticks(10);
    lights("held_plus_warn", 1'b1, 1'b0, 1'b0, 2'b01);
    Iack = 2'b01;
    tick();
    Iack = 2'b00;
    tick();
    lights("warn_after_ack", 1'b0, 1'b1, 1'b0, 2'b00);

    // Re-enter HELD on zone 0, then reset discards it.
    IT[0] = 1'b1; IS[0] = 1'b1;
    ticks(8);
    IT[0] = 1'b0; IS[0] = 1'b0;
    ticks(10);
    lights("held_again", 1'b1, 1'b0, 1'b0, 2'b01);
    rst = 1'b1;
    tick();
    lights("reset_mid_held", 1'b0, 1'b0, 1'b1, 2'b00);
    rst = 1'b0;

    // Zone 1 heat still present: warn re-appears with full latency after release.
    ticks(7);
    lights("rel_edge7", 1'b0, 1'b0, 1'b1, 2'b00);
    tick();
    lights("rel_edge8", 1'b0, 1'b1, 1'b0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
